iir_folded_n: RTL and testbench
===============================

# iir_folded_n

Parametrised N-fold IIR filter core: computes y(n) = x(n) + Σ c_k·y(n−k), k = 1..ORDER, with one shared multiplier and one adder time-multiplexed over ORDER clock cycles per sample. It is the generalised successor of the fixed 2-folded filter. It adds:
- an internally generated fold schedule, so no external switch input;
- configurable order and fixed-point format;
- a valid/ready sample handshake.

It sits between the sample source and the downstream decimation/output stage of the DSP chain.

## Interface
- W, 16: sample and coefficient width, two's complement.
- ORDER, 2: feedback taps, which is also the folding factor; legal range 1..8.
- FRAC, 0: fractional bits of the coefficients; 0 means plain integer arithmetic.

- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  xn holds a sample.
- in_ready  out  1  core accepts a sample this cycle.
- xn  in  W  input sample.
- coef  in  ORDER*W  coef[k*W-1:(k-1)*W] = c_k.
- out_valid  out  1  one-cycle pulse; yn is new.
- yn  out  W  output sample, held until the next result.
- sat  out  1  the result on yn was clamped; valid together with out_valid.

## Operation
- FSM states: IDLE, MAC.
- Accept: a sample is accepted on the edge where in_valid && in_ready. At that edge:
  - acc ← sext(xn) << FRAC;
  - coef is snapshotted; later coef changes do not affect the sample in flight;
  - k ← 1; state → MAC.
- MAC: each cycle acc ← acc + c_k·y_hist[k−1], and k increments.
- Last MAC cycle (k == ORDER), on its closing edge:
  - yn ← fit(acc_final >>> FRAC);
  - history shifts, with y_hist[0] ← yn;
  - out_valid pulses;
  - state → IDLE, unless a new sample is accepted on the same edge, in which case state → MAC.
- in_ready = !rst && (state == IDLE || (state == MAC && k == ORDER)).
- Overlap: accept and writeback on the same edge are legal. The new sample's first MAC uses the freshly written y_hist[0].
- Arithmetic:
  - multiplies are signed W×W → 2W;
  - the accumulator is ACC_W = 2W + FRAC + clog2(ORDER+1) bits, so it cannot overflow;
  - the right shift is arithmetic, i.e. it truncates toward −∞;
  - fit() either wraps or saturates to W bits (see Configuration);
  - the history stores the fitted W-bit yn.
- Reset:
  - state → IDLE; history, acc, k, yn ← 0; out_valid and sat ← 0;
  - an in-flight sample is discarded with no out_valid pulse;
  - coefficients are not stored across reset.

## Timing
- Latency: yn and out_valid are visible ORDER cycles after the accept edge.
- Throughput: one sample per ORDER cycles when in_valid is held high; in_ready is high for one cycle in every ORDER.
- With ORDER = 1, in_ready stays high continuously and the core produces one output per cycle.
- in_ready is low while rst is high and high in the first cycle after reset is released.
- in_valid without in_ready is ignored. The source must hold xn until the sample is accepted.
- yn holds its value between out_valid pulses.
- sat is 0 whenever out_valid is 0.

## Configuration
- IIR_SAT_EN defined:
  - fit() clamps to [−2^(W−1), 2^(W−1)−1];
  - sat is 1 with out_valid when a clamp occurred.
- IIR_SAT_EN undefined:
  - fit() keeps the low W bits (modulo 2^W wrap);
  - sat is tied to 0.

## Structure
- Package iir_folded_pkg holds:
  - the state enum typedef (IDLE, MAC);
  - MAX_ORDER = 8;
  - function acc_width(W, FRAC, ORDER).
- Sub-module iir_mac_unit: the shared signed multiplier plus accumulator register, with load/accumulate control and the fit/saturate stage.
- Top level holds: the FSM, the k counter, the coefficient snapshot, the history shift register, and the tap/coefficient muxes.

## Test plan
- Basic response, W=16, ORDER=2, FRAC=0, c1=2, c2=3, xn = −3, 5, 2, −2, 4 back-to-back → yn = −3, −1, −9, −23, −69.
- Handshake timing (same configuration) → out_valid exactly every 2 cycles, each pulse 2 cycles after its accept; in_ready alternates.
- Overflow, W=8, ORDER=1, c1=1, xn = 100, 100:
  - IIR_SAT_EN defined → yn = 100, 127, with sat=1 on the second output;
  - IIR_SAT_EN undefined → yn = 100, −56, with sat=0.
- Fixed point, W=16, FRAC=8, ORDER=1, c1=0x0080:
  - xn = 256, 256 → yn = 256, 384;
  - after reset, xn = −1, 0 → yn = −1, −1 (floor truncation).
- Reset mid-flight, ORDER=3: assert rst for 1 cycle during the MAC of a sample → no out_valid for that sample; next xn = 7 → yn = 7 (history cleared).
- Coefficient snapshot: change coef during MAC cycles → result uses the coefficients captured at accept; gaps in in_valid → no spurious out_valid.

Source files
------------

// File: rtl/iir_folded_pkg.sv
// Shared state type and sizing helpers for the folded N-order IIR core.
package iir_folded_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    MAC  = 1'b1
  } iir_state_e;

  localparam int MAX_ORDER = 8;
  localparam int K_W       = $clog2(MAX_ORDER + 1);

  // Wide enough that ORDER products plus the shifted sample can never overflow.
  function automatic int acc_width(input int w, input int frac, input int order);
    return 2 * w + frac + $clog2(order + 1);
  endfunction

endpackage

// File: rtl/iir_folded_n_if.sv
// Sample handshake and result bus of the folded IIR core; the core uses the slave side.
interface iir_folded_n_if
  import iir_folded_pkg::*;
#(
  parameter int W     = 16,
  parameter int ORDER = 2
);

  logic                 in_valid;
  logic                 in_ready;
  logic [W-1:0]         xn;
  logic [ORDER*W-1:0]   coef;
  logic                 out_valid;
  logic [W-1:0]         yn;
  logic                 sat;

  modport master (
    output in_valid, xn, coef,
    input  in_ready, out_valid, yn, sat
  );

  modport slave (
    input  in_valid, xn, coef,
    output in_ready, out_valid, yn, sat
  );

endinterface

// File: rtl/iir_folded_n_mac.sv
// Shared multiplier, accumulator and fit stage of the folded IIR core.
// Fit saturates when IIR_SAT_EN is defined and wraps to W bits otherwise.
module iir_mac_unit
  import iir_folded_pkg::*;
#(
  parameter int W     = 16,
  parameter int FRAC  = 0,
  parameter int ACC_W = 2 * W + 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic                accum,
  input  logic signed [W-1:0] xn,
  input  logic signed [W-1:0] coef_sel,
  input  logic signed [W-1:0] hist_sel,
  output logic signed [W-1:0] yfit,
  output logic                clamp
);

  logic signed [2*W-1:0]   prod;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] sum;
  logic signed [ACC_W-1:0] xn_ext;
  logic signed [ACC_W-1:0] load_val;
  logic signed [ACC_W-1:0] shifted;

  assign prod     = coef_sel * hist_sel;
  assign sum      = acc + {{(ACC_W-2*W){prod[2*W-1]}}, prod};
  assign xn_ext   = {{(ACC_W-W){xn[W-1]}}, xn};
  assign load_val = xn_ext <<< FRAC;
  // Arithmetic shift floors toward minus infinity, dropping the fractional bits.
  assign shifted  = sum >>> FRAC;

  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
    end else if (load) begin
      acc <= load_val;
    end else if (accum) begin
      acc <= sum;
    end
  end

`ifdef IIR_SAT_EN
  localparam logic signed [ACC_W-1:0] Y_MAX = {{(ACC_W-W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] Y_MIN = {{(ACC_W-W+1){1'b1}}, {(W-1){1'b0}}};

  always_comb begin
    yfit  = shifted[W-1:0];
    clamp = 1'b0;
    if (shifted > Y_MAX) begin
      yfit  = Y_MAX[W-1:0];
      clamp = 1'b1;
    end else if (shifted < Y_MIN) begin
      yfit  = Y_MIN[W-1:0];
      clamp = 1'b1;
    end
  end
`else
  assign yfit  = shifted[W-1:0];
  assign clamp = 1'b0;
`endif

endmodule

// File: rtl/iir_folded_n.sv
// N-fold IIR core y(n) = x(n) + sum c_k*y(n-k): one multiplier shared over ORDER cycles.
// Optional output saturation is enabled with the IIR_SAT_EN macro.
module iir_folded_n
  import iir_folded_pkg::*;
#(
  parameter int W     = 16,
  parameter int ORDER = 2,
  parameter int FRAC  = 0
) (
  input  logic          clk,
  input  logic          rst,
  iir_folded_n_if.slave bus
);

  localparam int             ACC_W  = acc_width(W, FRAC, ORDER);
  localparam logic [0:0]     S_IDLE = IDLE;
  localparam logic [0:0]     S_MAC  = MAC;
  localparam logic [K_W-1:0] K_LAST = K_W'(ORDER);

  logic [0:0]          state;
  logic [K_W-1:0]      k;
  logic signed [W-1:0] c_snap [ORDER];
  logic signed [W-1:0] y_hist [ORDER];
  logic signed [W-1:0] c_sel;
  logic signed [W-1:0] h_sel;
  logic signed [W-1:0] yfit;
  logic                clamp;
  logic                last;
  logic                accept;

  assign last         = (state == S_MAC) && (k == K_LAST);
  assign bus.in_ready = !rst && ((state == S_IDLE) || last);
  assign accept       = bus.in_valid && bus.in_ready;

  // Step k selects coefficient c_k and history tap y(n-k).
  always_comb begin
    c_sel = '0;
    h_sel = '0;
    for (int i = 0; i < ORDER; i++) begin
      if (k == K_W'(i + 1)) begin
        c_sel = c_snap[i];
        h_sel = y_hist[i];
      end
    end
  end

  // Snapshot keeps the sample in flight immune to later coefficient changes.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int i = 0; i < ORDER; i++) begin
        c_snap[i] <= bus.coef[i*W +: W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      k             <= '0;
      bus.out_valid <= 1'b0;
      bus.sat       <= 1'b0;
      bus.yn        <= '0;
      for (int i = 0; i < ORDER; i++) begin
        y_hist[i] <= '0;
      end
    end else begin
      bus.out_valid <= last;
      bus.sat       <= last && clamp;
      if (last) begin
        bus.yn    <= yfit;
        y_hist[0] <= yfit;
        for (int i = 1; i < ORDER; i++) begin
          y_hist[i] <= y_hist[i-1];
        end
      end
      // An accept on the writeback edge chains straight into the next sample.
      if (accept) begin
        state <= S_MAC;
        k     <= K_W'(1);
      end else if (last) begin
        state <= S_IDLE;
        k     <= '0;
      end else if (state == S_MAC) begin
        k <= k + 1'b1;
      end
    end
  end

  iir_mac_unit #(
    .W     (W),
    .FRAC  (FRAC),
    .ACC_W (ACC_W)
  ) u_mac (
    .clk      (clk),
    .rst      (rst),
    .load     (accept),
    .accum    (state == S_MAC),
    .xn       (bus.xn),
    .coef_sel (c_sel),
    .hist_sel (h_sel),
    .yfit     (yfit),
    .clamp    (clamp)
  );

endmodule

// File: tb/tb_iir_folded_n.sv
// Bench for iir_folded_n: four parameterisations, directed cases and random traffic
// scored against a plain-arithmetic model of the recurrence (honours IIR_SAT_EN).
module tb_iir_folded_n;

  typedef struct {
    longint y;
    bit     s;
    int     cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  bit   mon_en = 1'b0;
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;

  int p_w     [4] = '{16, 8, 16, 16};
  int p_frac  [4] = '{0, 0, 8, 0};
  int p_order [4] = '{2, 1, 1, 3};

  longint cur_c [9];
  longint mh [4][8];
  exp_t   expq0[$], expq1[$], expq2[$], expq3[$];
  exp_t   obs0[$], obs1[$], obs2[$], obs3[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  iir_folded_n_if #(.W(16), .ORDER(2)) ifa ();
  iir_folded_n_if #(.W(8),  .ORDER(1)) ifb ();
  iir_folded_n_if #(.W(16), .ORDER(1)) ifc ();
  iir_folded_n_if #(.W(16), .ORDER(3)) ifd ();

  iir_folded_n #(.W(16), .ORDER(2), .FRAC(0)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
  iir_folded_n #(.W(8),  .ORDER(1), .FRAC(0)) dut_b (.clk(clk), .rst(rst), .bus(ifb));
  iir_folded_n #(.W(16), .ORDER(1), .FRAC(8)) dut_c (.clk(clk), .rst(rst), .bus(ifc));
  iir_folded_n #(.W(16), .ORDER(3), .FRAC(0)) dut_d (.clk(clk), .rst(rst), .bus(ifd));

  function automatic int qsize(input int d);
    case (d)
      0:       return expq0.size();
      1:       return expq1.size();
      2:       return expq2.size();
      default: return expq3.size();
    endcase
  endfunction

  function automatic void push_exp(input int d, input exp_t e);
    case (d)
      0:       expq0.push_back(e);
      1:       expq1.push_back(e);
      2:       expq2.push_back(e);
      default: expq3.push_back(e);
    endcase
  endfunction

  function automatic exp_t pop_exp(input int d);
    case (d)
      0:       return expq0.pop_front();
      1:       return expq1.pop_front();
      2:       return expq2.pop_front();
      default: return expq3.pop_front();
    endcase
  endfunction

  function automatic void push_obs(input int d, input exp_t e);
    case (d)
      0:       obs0.push_back(e);
      1:       obs1.push_back(e);
      2:       obs2.push_back(e);
      default: obs3.push_back(e);
    endcase
  endfunction

  function automatic int obs_size(input int d);
    case (d)
      0:       return obs0.size();
      1:       return obs1.size();
      2:       return obs2.size();
      default: return obs3.size();
    endcase
  endfunction

  function automatic exp_t get_obs(input int d, input int i);
    exp_t e;
    e.y = 0; e.s = 1'b0; e.cyc = 0;
    if (i < obs_size(d)) begin
      case (d)
        0:       e = obs0[i];
        1:       e = obs1[i];
        2:       e = obs2[i];
        default: e = obs3[i];
      endcase
    end
    return e;
  endfunction

  function automatic void clear_all();
    expq0.delete(); expq1.delete(); expq2.delete(); expq3.delete();
    obs0.delete();  obs1.delete();  obs2.delete();  obs3.delete();
    for (int d = 0; d < 4; d++)
      for (int k = 0; k < 8; k++) mh[d][k] = 0;
  endfunction

  // Reference: floor((x*2^F + sum c_k*y(n-k)) / 2^F), then clamp or wrap to W bits.
  function automatic longint model_step(input int d, input longint x, output bit clamped);
    longint num, scale, q, y, lim;
    scale = longint'(1) << p_frac[d];
    num   = x * scale;
    for (int k = 1; k <= p_order[d]; k++) num += cur_c[k] * mh[d][k-1];
    q = num / scale;
    if (num < 0 && (num % scale) != 0) q = q - 1;
    lim     = longint'(1) << (p_w[d] - 1);
    clamped = 1'b0;
`ifdef IIR_SAT_EN
    if (q > lim - 1) begin y = lim - 1; clamped = 1'b1; end
    else if (q < -lim) begin y = -lim; clamped = 1'b1; end
    else y = q;
`else
    y = q % (2 * lim);
    if (y >= lim) y -= 2 * lim;
    else if (y < -lim) y += 2 * lim;
`endif
    for (int k = p_order[d] - 1; k >= 1; k--) mh[d][k] = mh[d][k-1];
    mh[d][0] = y;
    return y;
  endfunction

  task automatic read_dut(input int d, output bit rdy, output bit ov, output longint y, output bit s);
    case (d)
      0:       begin rdy = ifa.in_ready; ov = ifa.out_valid; y = longint'($signed(ifa.yn)); s = ifa.sat; end
      1:       begin rdy = ifb.in_ready; ov = ifb.out_valid; y = longint'($signed(ifb.yn)); s = ifb.sat; end
      2:       begin rdy = ifc.in_ready; ov = ifc.out_valid; y = longint'($signed(ifc.yn)); s = ifc.sat; end
      default: begin rdy = ifd.in_ready; ov = ifd.out_valid; y = longint'($signed(ifd.yn)); s = ifd.sat; end
    endcase
  endtask

  task automatic drive(input int d, input bit v, input longint x);
    logic [127:0] cv;
    cv = '0;
    for (int k = 1; k <= p_order[d]; k++) begin
      if (p_w[d] == 8) cv[(k-1)*8 +: 8] = 8'(cur_c[k]);
      else             cv[(k-1)*16 +: 16] = 16'(cur_c[k]);
    end
    case (d)
      0:       begin ifa.in_valid = v; ifa.xn = 16'(x); ifa.coef = 32'(cv); end
      1:       begin ifb.in_valid = v; ifb.xn = 8'(x);  ifb.coef = 8'(cv);  end
      2:       begin ifc.in_valid = v; ifc.xn = 16'(x); ifc.coef = 16'(cv); end
      default: begin ifd.in_valid = v; ifd.xn = 16'(x); ifd.coef = 48'(cv); end
    endcase
  endtask

  // Offer one sample at a negedge, wait for in_ready, record the model result.
  task automatic applyStimulus(input int d, input longint x, output int waits);
    bit rdy, ov, s;
    longint y;
    exp_t e;
    waits = 0;
    drive(d, 1'b1, x);
    read_dut(d, rdy, ov, y, s);
    while (!rdy && waits < 40) begin
      @(negedge clk);
      waits++;
      read_dut(d, rdy, ov, y, s);
    end
    vectors++;
    assert (rdy === 1'b1) else begin
      miscompares++;
      $error("[TB] FAIL accept_timeout dut%0d: in_ready=%0b required=1", d, rdy);
    end
    if (rdy) begin
      e.y   = model_step(d, x, e.s);
      e.cyc = cyc + 1 + p_order[d];
      push_exp(d, e);
    end
    @(negedge clk);
    drive(d, 1'b0, x);
  endtask

  task automatic checkOutput(input int d);
    bit rdy, ov, s;
    longint y;
    exp_t e, o;
    read_dut(d, rdy, ov, y, s);
    if (ov !== 1'b1) begin
      vectors++;
      assert (s === 1'b0) else begin
        miscompares++;
        $error("[TB] FAIL sat_without_valid dut%0d: sat=%0b required=0", d, s);
      end
    end else begin
      o.y = y; o.s = s; o.cyc = cyc;
      push_obs(d, o);
      vectors++;
      assert (qsize(d) > 0) else begin
        miscompares++;
        $error("[TB] FAIL spurious_out_valid dut%0d: out_valid=1 required=0", d);
      end
      if (qsize(d) > 0) begin
        e = pop_exp(d);
        vectors++;
        assert (y === e.y) else begin
          miscompares++;
          $error("[TB] FAIL yn dut%0d: observed=%0d expected=%0d", d, y, e.y);
        end
        vectors++;
        assert (s === e.s) else begin
          miscompares++;
          $error("[TB] FAIL sat dut%0d: observed=%0b expected=%0b", d, s, e.s);
        end
        vectors++;
        assert (cyc === e.cyc) else begin
          miscompares++;
          $error("[TB] FAIL latency dut%0d: out_valid at cycle %0d required %0d", d, cyc, e.cyc);
        end
      end
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) for (int d = 0; d < 4; d++) checkOutput(d);
  end

  task automatic drain();
    int t = 0;
    while ((qsize(0) + qsize(1) + qsize(2) + qsize(3)) != 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    vectors++;
    assert ((qsize(0) + qsize(1) + qsize(2) + qsize(3)) === 0) else begin
      miscompares++;
      $error("[TB] FAIL drain_timeout: pending=%0d required=0", qsize(0) + qsize(1) + qsize(2) + qsize(3));
    end
  endtask

  task automatic doReset(input int ncyc, input int dchk);
    bit rdy, ov, s;
    longint y;
    rst = 1'b1;
    clear_all();
    repeat (ncyc) @(negedge clk);
    read_dut(dchk, rdy, ov, y, s);
    vectors++;
    assert (rdy === 1'b0) else begin
      miscompares++;
      $error("[TB] FAIL in_ready_during_reset dut%0d: observed=%0b expected=0", dchk, rdy);
    end
    rst = 1'b0;
    #1;
    read_dut(dchk, rdy, ov, y, s);
    vectors++;
    assert (rdy === 1'b1) else begin
      miscompares++;
      $error("[TB] FAIL in_ready_after_reset dut%0d: observed=%0b expected=1", dchk, rdy);
    end
    @(negedge clk);
  endtask

  task automatic expectObs(input int d, input int i, input longint y, input bit s, input string tag);
    exp_t o;
    o = get_obs(d, i);
    vectors++;
    assert (obs_size(d) > i && o.y === y && o.s === s) else begin
      miscompares++;
      $error("[TB] FAIL %s dut%0d[%0d]: observed yn=%0d sat=%0b (count %0d) expected yn=%0d sat=%0b",
             tag, d, i, o.y, o.s, obs_size(d), y, s);
    end
  endtask

  initial begin
    int w, d, g;
    longint xs [5];
    longint ya [5];
    logic [15:0] r16;

    rst = 1'b1;
    for (int i = 0; i < 4; i++) drive(i, 1'b0, 0);
    repeat (2) @(negedge clk);
    vectors++;
    assert (ifa.out_valid === 1'b0 && ifa.yn === 16'd0) else begin
      miscompares++;
      $error("[TB] FAIL reset_outputs dut0: out_valid=%0b yn=%0d expected 0/0", ifa.out_valid, ifa.yn);
    end
    mon_en = 1'b1;
    doReset(1, 0);

    // Basic response, back-to-back, in_ready alternating on ORDER=2.
    $display("[TB] basic response");
    cur_c[1] = 2; cur_c[2] = 3;
    xs = '{-3, 5, 2, -2, 4};
    ya = '{-3, -1, -9, -23, -69};
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, xs[i], w);
      if (i > 0) begin
        vectors++;
        assert (w === 1) else begin
          miscompares++;
          $error("[TB] FAIL ready_alternation: waited %0d cycles required 1", w);
        end
      end
    end
    drain();
    for (int i = 0; i < 5; i++) expectObs(0, i, ya[i], 1'b0, "basic");

    // Overflow on W=8, ORDER=1 also checks in_ready stays high.
    $display("[TB] overflow");
    cur_c[1] = 1;
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1, 100, w);
      vectors++;
      assert (w === 0) else begin
        miscompares++;
        $error("[TB] FAIL ready_order1: waited %0d cycles required 0", w);
      end
    end
    drain();
    expectObs(1, 0, 100, 1'b0, "overflow");
`ifdef IIR_SAT_EN
    expectObs(1, 1, 127, 1'b1, "overflow");
`else
    expectObs(1, 1, -56, 1'b0, "overflow");
`endif

    // Fixed point with c1 = 0.5 in Q8.
    $display("[TB] fixed point");
    cur_c[1] = 128;
    applyStimulus(2, 256, w);
    applyStimulus(2, 256, w);
    drain();
    expectObs(2, 0, 256, 1'b0, "fixed");
    expectObs(2, 1, 384, 1'b0, "fixed");
    doReset(1, 2);
    applyStimulus(2, -1, w);
    applyStimulus(2, 0, w);
    drain();
    expectObs(2, 0, -1, 1'b0, "fixed_floor");
    expectObs(2, 1, -1, 1'b0, "fixed_floor");

    // Reset during MAC on ORDER=3 discards the sample and clears history.
    $display("[TB] reset mid-flight");
    for (int i = 0; i < 3; i++) begin
      for (int k = 1; k <= 3; k++) begin r16 = 16'($urandom); cur_c[k] = longint'($signed(r16)); end
      r16 = 16'($urandom);
      applyStimulus(3, longint'($signed(r16)), w);
    end
    drain();
    applyStimulus(3, 1234, w);
    doReset(1, 3);
    repeat (6) @(negedge clk);
    for (int k = 1; k <= 3; k++) cur_c[k] = 5 * k - 7;
    applyStimulus(3, 7, w);
    drain();
    expectObs(3, 0, 7, 1'b0, "after_reset");
    vectors++;
    assert (obs_size(3) === 1) else begin
      miscompares++;
      $error("[TB] FAIL discarded_sample dut3: outputs=%0d required=1", obs_size(3));
    end

    // Coefficient bus scrambled during MAC, with gaps between samples.
    $display("[TB] coefficient snapshot");
    for (int i = 0; i < 8; i++) begin
      for (int k = 1; k <= 2; k++) begin r16 = 16'($urandom_range(0, 15)); cur_c[k] = longint'(r16) - 8; end
      r16 = 16'($urandom);
      applyStimulus(0, longint'($signed(r16)), w);
      ifa.coef = 32'($urandom);
      g = int'($urandom_range(0, 3));
      repeat (g) @(negedge clk);
    end
    drain();

    // Random traffic across the ORDER=2 and ORDER=3 cores.
    $display("[TB] random traffic");
    for (int i = 0; i < 60; i++) begin
      d = ($urandom_range(0, 1) == 0) ? 0 : 3;
      if ($urandom_range(0, 3) == 0) begin
        for (int k = 1; k <= 3; k++) begin r16 = 16'($urandom); cur_c[k] = longint'($signed(r16)); end
      end else begin
        for (int k = 1; k <= 3; k++) begin r16 = 16'($urandom_range(0, 6)); cur_c[k] = longint'(r16) - 3; end
      end
      r16 = 16'($urandom);
      applyStimulus(d, longint'($signed(r16)), w);
      g = int'($urandom_range(0, 2));
      repeat (g) @(negedge clk);
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
